id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the RV32I core, sitting directly upstream of the ALU. Holds one decoded instruction and drives the ALU's `data1`, `data2` and operation inputs through a valid/ready handshake. Applies operand forwarding from the EX/MEM and MEM/WB stages, and keeps forwarded values in its holding registers while stalled. Supports a pipeline flush for branch redirects.

---
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode-to-execute pipeline register for the RV32I core, directly upstream of
// the ALU. It holds one decoded instruction and presents ALU operands through a
// valid/ready handshake. Operand forwarding from EX/MEM and MEM/WB is applied on
// the output side. While stalled, the forwarded operands are written back into
// the holding registers, so a forwarded value survives after its producer retires.
//
// Ports
//   clk, rst_n                     rising-edge clock, async active-low reset
//   in_valid / in_ready            upstream handshake
//   in_pc, in_rs1_data, in_rs2_data, in_imm   decoded operands (32b)
//   in_rs1_addr, in_rs2_addr, in_rd_addr      register indices (5b)
//   in_alu_op, in_use_pc, in_use_imm, in_reg_write  control
//   exm_wen/exm_rd/exm_data        EX/MEM forwarding source
//   wb_wen/wb_rd/wb_data           MEM/WB forwarding source
//   flush                          kill the held instruction
//   out_valid / out_ready          downstream handshake
//   data1, data2, store_data       ALU operands and forwarded rs2
//   alu_op, out_rd_addr, out_reg_write        destination/control info
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic [4:0]  in_alu_op,
   input  logic        in_use_pc,
   input  logic        in_use_imm,
   input  logic        in_reg_write,
   input  logic        exm_wen,
   input  logic [4:0]  exm_rd,
   input  logic [31:0] exm_data,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] data1,
   output logic [31:0] data2,
   output logic [4:0]  alu_op,
   output logic [31:0] store_data,
   output logic [4:0]  out_rd_addr,
   output logic        out_reg_write
);

   logic        v;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] imm;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic [4:0]  op;
   logic        use_pc;
   logic        use_imm;
   logic        reg_write;

   logic        accept;
   logic        stall;
   logic [31:0] rs1_fwd;
   logic [31:0] rs2_fwd;

   // Flush forces in_ready high so an upstream stage flushed in the same cycle
   // is never blocked; whatever it offers is discarded by the accept term.
   assign in_ready = !v || out_ready || flush;
   assign accept   = in_valid && in_ready && !flush;
   assign stall    = v && !out_ready && !flush;

   // EX/MEM is the younger producer, so it takes priority over MEM/WB.
   // x0 is hardwired zero and must never pick up a forwarded value.
   always_comb begin
      rs1_fwd = rs1;
      if (exm_wen && (exm_rd == rs1_addr) && (rs1_addr != 5'd0))
         rs1_fwd = exm_data;
      else if (wb_wen && (wb_rd == rs1_addr) && (rs1_addr != 5'd0))
         rs1_fwd = wb_data;
   end

   always_comb begin
      rs2_fwd = rs2;
      if (exm_wen && (exm_rd == rs2_addr) && (rs2_addr != 5'd0))
         rs2_fwd = exm_data;
      else if (wb_wen && (wb_rd == rs2_addr) && (rs2_addr != 5'd0))
         rs2_fwd = wb_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v         <= 1'b0;
         pc        <= 32'd0;
         rs1       <= 32'd0;
         rs2       <= 32'd0;
         imm       <= 32'd0;
         rs1_addr  <= 5'd0;
         rs2_addr  <= 5'd0;
         rd_addr   <= 5'd0;
         op        <= 5'd0;
         use_pc    <= 1'b0;
         use_imm   <= 1'b0;
         reg_write <= 1'b0;
      end else if (accept) begin
         // Operands are captured raw; forwarding is resolved on the output side.
         v         <= 1'b1;
         pc        <= in_pc;
         rs1       <= in_rs1_data;
         rs2       <= in_rs2_data;
         imm       <= in_imm;
         rs1_addr  <= in_rs1_addr;
         rs2_addr  <= in_rs2_addr;
         rd_addr   <= in_rd_addr;
         op        <= in_alu_op;
         use_pc    <= in_use_pc;
         use_imm   <= in_use_imm;
         reg_write <= in_reg_write;
      end else if (stall) begin
         rs1 <= rs1_fwd;
         rs2 <= rs2_fwd;
      end else begin
         // Reached on flush, on a consume with no new accept, or when idle.
         v <= 1'b0;
      end
   end

   assign out_valid     = v;
   assign data1         = use_pc  ? pc  : rs1_fwd;
   assign data2         = use_imm ? imm : rs2_fwd;
   assign store_data    = rs2_fwd;
   assign alu_op        = op;
   assign out_rd_addr   = rd_addr;
   assign out_reg_write = reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op;
   logic        in_use_pc, in_use_imm, in_reg_write;
   logic        exm_wen, wb_wen;
   logic [4:0]  exm_rd, wb_rd;
   logic [31:0] exm_data, wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] data1, data2, store_data;
   logic [4:0]  alu_op, out_rd_addr;
   logic        out_reg_write;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_alu_op(in_alu_op), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
      .in_reg_write(in_reg_write),
      .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .data1(data1), .data2(data2), .alu_op(alu_op), .store_data(store_data),
      .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
   );

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  a1, a2, rd, op;
      logic        upc, uimm, rw;
   } instr_t;

   instr_t sb[$];
   int tests = 0;
   int fails = 0;
   int consumed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Architectural view of a register read: the most recent in-flight writer
   // (EX/MEM, then MEM/WB) supplies the value; x0 is always the held value.
   function automatic logic [31:0] view(input logic [4:0] a, input logic [31:0] held);
      if (a == 5'd0) return held;
      if (exm_wen && exm_rd == a) return exm_data;
      if (wb_wen && wb_rd == a) return wb_data;
      return held;
   endfunction

   // Monitor / scoreboard: samples on the falling edge, mid-cycle.
   instr_t      e;
   logic [31:0] f1, f2;
   logic        exp_rdy;
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         exp_rdy = (sb.size() == 0) || out_ready || flush;
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
         if (sb.size() != 0) begin
            e  = sb[0];
            f1 = view(e.a1, e.rs1);
            f2 = view(e.a2, e.rs2);
            chk("data1", data1, e.upc ? e.pc : f1);
            chk("data2", data2, e.uimm ? e.imm : f2);
            chk("store_data", store_data, f2);
            chk("ctrl", {19'd0, alu_op, out_rd_addr, out_reg_write, 2'b00},
                        {19'd0, e.op, e.rd, e.rw, 2'b00});
            if (flush) sb.delete();
            else if (out_ready) begin
               void'(sb.pop_front());
               consumed++;
            end else begin
               // A value seen while waiting stays with the instruction.
               sb[0].rs1 = f1;
               sb[0].rs2 = f2;
            end
         end
         if (in_valid && exp_rdy && !flush) begin
            e.pc = in_pc; e.rs1 = in_rs1_data; e.rs2 = in_rs2_data; e.imm = in_imm;
            e.a1 = in_rs1_addr; e.a2 = in_rs2_addr; e.rd = in_rd_addr; e.op = in_alu_op;
            e.upc = in_use_pc; e.uimm = in_use_imm; e.rw = in_reg_write;
            sb.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
      in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_alu_op = 0;
      in_use_pc = 0; in_use_imm = 0; in_reg_write = 0;
      exm_wen = 0; exm_rd = 0; exm_data = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
      flush = 0; out_ready = 1;
   endtask

   task automatic drain();
      clear_inputs();
      step();
      step();
   endtask

   task automatic rand_instr();
      in_pc = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom); in_alu_op = 5'($urandom);
      in_use_pc = 1'($urandom); in_use_imm = 1'($urandom); in_reg_write = 1'($urandom);
   endtask

   logic [5:0] pat;
   logic [9:0] low_mask;
   int k, c0;

   initial begin
      rst_n = 0;
      clear_inputs();
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_data", data1 | data2 | store_data, 32'd0);
      chk("rst_ctrl", {21'd0, alu_op, out_rd_addr, out_reg_write}, 32'd0);
      step();
      rst_n = 1;
      step();

      // single pass
      in_valid = 1; in_rs1_data = 5; in_rs2_data = 7; in_alu_op = 0;
      in_rs1_addr = 1; in_rs2_addr = 2;
      step();
      clear_inputs();
      chk("sp_valid", {31'd0, out_valid}, 32'd1);
      chk("sp_data1", data1, 32'd5);
      chk("sp_data2", data2, 32'd7);
      step();
      chk("sp_drop", {31'd0, out_valid}, 32'd0);

      // forward priority
      in_valid = 1; in_rs1_addr = 3; in_rs1_data = 1; out_ready = 0;
      step();
      in_valid = 0;
      exm_wen = 1; exm_rd = 3; exm_data = 32'hAA;
      wb_wen = 1; wb_rd = 3; wb_data = 32'hBB;
      #1 chk("fwd_exm", data1, 32'hAA);
      exm_wen = 0;
      #1 chk("fwd_wb", data1, 32'hBB);
      step();
      clear_inputs();
      in_valid = 1; in_rs1_addr = 0; in_rs1_data = 1;
      step();
      in_valid = 0; out_ready = 0;
      exm_wen = 1; exm_rd = 0; exm_data = 32'hAA;
      wb_wen = 1; wb_rd = 0; wb_data = 32'hBB;
      #1 chk("fwd_x0", data1, 32'd1);
      step();
      drain();

      // stall refresh
      in_valid = 1; in_rs2_addr = 4; in_rs2_data = 32'h55; out_ready = 0;
      step();
      in_valid = 0;
      exm_wen = 1; exm_rd = 4; exm_data = 32'h1234;
      step();
      exm_wen = 0;
      #1 chk("refresh_d2", data2, 32'h1234);
      chk("refresh_sd", store_data, 32'h1234);
      step();
      step();
      chk("refresh_hold", store_data, 32'h1234);
      drain();

      // pc / imm select
      in_valid = 1; in_use_pc = 1; in_use_imm = 1; in_pc = 32'h100;
      in_imm = 32'hFFFF_FFFC; in_rs2_addr = 5; in_rs2_data = 9; in_rs1_data = 32'h77;
      step();
      clear_inputs();
      chk("sel_d1", data1, 32'h100);
      chk("sel_d2", data2, 32'hFFFF_FFFC);
      chk("sel_sd", store_data, 32'd9);
      step();

      // flush with a simultaneous offer
      in_valid = 1; in_pc = 32'h200; out_ready = 0;
      step();
      flush = 1; in_pc = 32'h300;
      #1 chk("flush_rdy", {31'd0, in_ready}, 32'd1);
      step();
      flush = 0; in_valid = 0;
      chk("flush_empty", {31'd0, out_valid}, 32'd0);
      drain();

      // back-to-back with backpressure
      pat = 6'b111001;
      low_mask = '0;
      k = 0;
      c0 = consumed;
      for (int c = 0; c < 10; c++) begin
         out_ready = (c < 6) ? pat[c] : 1'b1;
         in_valid = (k < 4);
         if (k < 4) begin
            rand_instr();
            in_pc = 32'h1000 + 32'(k) * 4;
         end
         #1;
         if (!in_ready) low_mask[c] = 1'b1;
         if (in_valid && in_ready) k++;
         step();
      end
      clear_inputs();
      chk("b2b_stalls", {22'd0, low_mask}, 32'h6);
      chk("b2b_issued", k, 4);
      chk("b2b_consumed", consumed - c0, 4);

      // reset in the middle of a stall
      in_valid = 1; rand_instr(); out_ready = 0;
      step();
      in_valid = 0;
      step();
      #2 rst_n = 0;
      #1 chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_data", data1 | data2 | store_data, 32'd0);
      step();
      rst_n = 1;
      clear_inputs();
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_instr();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         exm_wen = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_data = $urandom;
         wb_wen  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 3)); wb_data  = $urandom;
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
